// File: rtl/oled_iic_writer.sv
// -----------------------------------------------------------------------------
// oled_iic_writer
//
// Byte-level I2C master for an SSD1306 OLED. Each accepted request sends one
// 24-bit word as START, address byte, control byte, payload byte (each followed
// by an ACK slot), STOP. It then pulses write_done for one cycle so the upstream
// sequencer can advance.
//
// Every bus slot is four quarters (q0..q3) of QUARTER system clocks. A slot is
// START, one data BIT, one ACK, or STOP.
//
// Ports
//   sys_clk     system clock (single domain)
//   rst_n       asynchronous active-low reset; releases the bus at once
//   write_req   upstream request, held high while words are pending
//   write_data  {address byte, control byte, payload byte}, sampled on accept
//   write_done  one-cycle pulse when a transfer ends (ACKed or aborted)
//   ack_err     slave NACKed a byte of the latest transfer
//   busy        high from the cycle after accept up to and including write_done
//   iic_scl     SCL, push-pull
//   iic_sda     SDA, open-drain: driven low or released, never driven high
// -----------------------------------------------------------------------------
module oled_iic_writer #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int IIC_FREQ = 400_000
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        write_req,
  input  logic [23:0] write_data,
  output logic        write_done,
  output logic        ack_err,
  output logic        busy,
  output logic        iic_scl,
  inout  wire         iic_sda
);

  localparam int QUARTER = CLK_FREQ / (4 * IIC_FREQ);
  localparam int QW      = (QUARTER > 1) ? $clog2(QUARTER) : 1;

  if (QUARTER < 2) begin : g_quarter_check
    $error("oled_iic_writer: CLK_FREQ/(4*IIC_FREQ) must be at least 2");
  end

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_BIT   = 3'd2;
  localparam logic [2:0] S_ACK   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [QW-1:0] qcnt_q,  qcnt_d;   // cycle within the current quarter
  logic [1:0]    phase_q, phase_d;  // quarter within the current slot
  logic [2:0]    bit_q,   bit_d;    // bit within the current byte
  logic [1:0]    byte_q,  byte_d;   // byte within the current word
  logic [23:0]   shift_q, shift_d;  // MSB is always the bit on the wire
  logic          ack_err_q, ack_err_d;

  logic active;
  logic quarter_end;
  logic slot_end;
  logic sda_in;
  logic sda_low;

  assign sda_in      = iic_sda;
  assign active      = (state_q == S_START) || (state_q == S_BIT) ||
                       (state_q == S_ACK)   || (state_q == S_STOP);
  assign quarter_end = (qcnt_q == QW'(QUARTER - 1));
  assign slot_end    = quarter_end && (phase_q == 2'd3);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    qcnt_d    = qcnt_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    shift_d   = shift_q;
    ack_err_d = ack_err_q;

    // The quarter/phase counters wrap to zero at the end of STOP, so they
    // are already zero whenever IDLE is entered.
    if (active) begin
      qcnt_d = quarter_end ? '0 : qcnt_q + QW'(1);
      if (quarter_end) begin
        phase_d = phase_q + 2'd1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (write_req) begin
          shift_d   = write_data;
          ack_err_d = 1'b0;
          byte_d    = 2'd0;
          state_d   = S_START;
        end
      end

      S_START: begin
        if (slot_end) begin
          state_d = S_BIT;
        end
      end

      S_BIT: begin
        if (slot_end) begin
          shift_d = {shift_q[22:0], 1'b0};
          if (bit_q == 3'd7) begin
            bit_d   = 3'd0;
            state_d = S_ACK;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end

      S_ACK: begin
        // Sample on the last cycle of q2, while SCL is still high.
        if ((phase_q == 2'd2) && quarter_end && sda_in) begin
          ack_err_d = 1'b1;
        end
        // ack_err is cleared on accept and any NACK ends the word, so a set
        // flag here can only mean this byte was NACKed.
        if (slot_end) begin
          if (ack_err_q || (byte_q == 2'd2)) begin
            state_d = S_STOP;
          end else begin
            byte_d  = byte_q + 2'd1;
            state_d = S_BIT;
          end
        end
      end

      S_STOP: begin
        if (slot_end) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        // write_req is deliberately ignored here so upstream has a cycle to
        // present the next word in response to write_done.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      qcnt_q    <= '0;
      phase_q   <= 2'd0;
      bit_q     <= 3'd0;
      byte_q    <= 2'd0;
      shift_q   <= 24'd0;
      ack_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values of the previous cycle, independent of statement order.
      state_q   <= state_d;
      qcnt_q    <= qcnt_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      shift_q   <= shift_d;
      ack_err_q <= ack_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Bus waveforms, decoded from state and quarter. Reset forces IDLE, so the
  // bus is released in the same cycle reset asserts.
  // ---------------------------------------------------------------------------
  always_comb begin
    iic_scl = 1'b1;
    sda_low = 1'b0;
    case (state_q)
      S_START: begin
        iic_scl = (phase_q == 2'd0) || (phase_q == 2'd1);
        sda_low = (phase_q != 2'd0);
      end
      S_BIT: begin
        iic_scl = (phase_q == 2'd1) || (phase_q == 2'd2);
        sda_low = ~shift_q[23];
      end
      S_ACK: begin
        iic_scl = (phase_q == 2'd1) || (phase_q == 2'd2);
        sda_low = 1'b0;
      end
      S_STOP: begin
        iic_scl = (phase_q != 2'd0);
        sda_low = (phase_q == 2'd0) || (phase_q == 2'd1);
      end
      default: begin
        iic_scl = 1'b1;
        sda_low = 1'b0;
      end
    endcase
  end

  assign iic_sda    = sda_low ? 1'b0 : 1'bz;
  assign write_done = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign ack_err    = ack_err_q;

endmodule

// File: tb/tb_oled_iic_writer.sv
// -----------------------------------------------------------------------------
// Testbench for oled_iic_writer.
//
// Instance dut runs at the default 400 kHz. Its SDA line has a pull-up and a
// slave model that decodes START/bytes/STOP and ACKs every byte except the one
// selected by nack_byte.
//
// Instance dut_s runs at 100 kHz. It has only a pull-up and no slave, so every
// transfer it makes is NACKed on the first byte. It is used to check quarter
// timing, SCL duty, SDA stability and idle behaviour.
// -----------------------------------------------------------------------------
module tb_oled_iic_writer;

  localparam int Q_FAST   = 31;
  localparam int Q_SLOW   = 125;
  localparam int FULL_LAT = 1 + 116 * Q_FAST;          // 3597
  localparam int LIMIT    = 20000;

  logic        sys_clk = 1'b0;
  logic        rst_n   = 1'b0;

  logic        write_req  = 1'b0;
  logic [23:0] write_data = 24'd0;
  logic        write_done;
  logic        ack_err;
  logic        busy;
  logic        iic_scl;
  wire         iic_sda;

  logic        write_req_s  = 1'b0;
  logic [23:0] write_data_s = 24'd0;
  logic        write_done_s;
  logic        ack_err_s;
  logic        busy_s;
  logic        scl_s;
  wire         sda_s;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 sys_clk = ~sys_clk;

  oled_iic_writer dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .write_req  (write_req),
    .write_data (write_data),
    .write_done (write_done),
    .ack_err    (ack_err),
    .busy       (busy),
    .iic_scl    (iic_scl),
    .iic_sda    (iic_sda)
  );

  oled_iic_writer #(.CLK_FREQ(50_000_000), .IIC_FREQ(100_000)) dut_s (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .write_req  (write_req_s),
    .write_data (write_data_s),
    .write_done (write_done_s),
    .ack_err    (ack_err_s),
    .busy       (busy_s),
    .iic_scl    (scl_s),
    .iic_sda    (sda_s)
  );

  pullup pu_main (iic_sda);
  pullup pu_slow (sda_s);

  // ---------------------------------------------------------------------------
  // Slave / bus decoder for the fast instance
  // ---------------------------------------------------------------------------
  logic       slave_low = 1'b0;
  int         nack_byte = 0;       // 0: ACK all, k: NACK byte k (1..3)
  logic       prev_scl  = 1'b1;
  logic       prev_sda  = 1'b1;
  logic       in_frame  = 1'b0;
  logic [7:0] sh        = 8'd0;
  logic [7:0] cap [4];
  int         bitcnt    = 0;
  int         byte_idx  = 0;
  int         start_cnt = 0;
  int         stop_cnt  = 0;

  assign iic_sda = slave_low ? 1'b0 : 1'bz;

  always @(negedge sys_clk) begin
    if (prev_scl && iic_scl && prev_sda && !iic_sda) begin
      in_frame  = 1'b1;
      bitcnt    = 0;
      byte_idx  = 0;
      slave_low = 1'b0;
      start_cnt = start_cnt + 1;
    end else if (prev_scl && iic_scl && !prev_sda && iic_sda) begin
      in_frame = 1'b0;
      stop_cnt = stop_cnt + 1;
    end else if (in_frame && !prev_scl && iic_scl) begin
      if (bitcnt < 8) sh = {sh[6:0], iic_sda};
      bitcnt = bitcnt + 1;
    end else if (in_frame && prev_scl && !iic_scl) begin
      if (bitcnt == 8) begin
        if (byte_idx < 4) cap[byte_idx] = sh;
        slave_low = (nack_byte != byte_idx + 1);
      end else if (bitcnt == 9) begin
        slave_low = 1'b0;
        bitcnt    = 0;
        byte_idx  = byte_idx + 1;
      end
    end
    prev_scl = iic_scl;
    prev_sda = iic_sda;
  end

  // Starts a transfer on the fast instance (call just after a posedge) and
  // returns the number of cycles from the accept cycle to write_done.
  task automatic run_xfer(input logic [23:0] data, input bit hold, output int lat);
    write_data = data;
    write_req  = 1'b1;
    lat = -1;
    for (int k = 0; k < LIMIT; k++) begin
      @(negedge sys_clk);
      if (k == 1 && !hold) write_req = 1'b0;
      if (write_done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int bad_idle;
    #2;
    n_cmp++; if (iic_scl !== 1'b1)   begin n_bad++; $display("FAIL reset_scl: got %b want 1", iic_scl); end
    n_cmp++; if (iic_sda !== 1'b1)   begin n_bad++; $display("FAIL reset_sda: got %b want 1 (released)", iic_sda); end
    n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (write_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", write_done); end
    n_cmp++; if (ack_err !== 1'b0)   begin n_bad++; $display("FAIL reset_ack_err: got %b want 0", ack_err); end
    @(posedge sys_clk); #1 rst_n = 1'b1;
    bad_idle = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge sys_clk);
      if (iic_scl !== 1'b1 || iic_sda !== 1'b1 || busy !== 1'b0) bad_idle++;
    end
    n_cmp++; if (bad_idle !== 0) begin n_bad++; $display("FAIL idle_after_reset: got %0d bad cycles want 0", bad_idle); end
  endtask

  task automatic test_single;
    int lat, s0, p0;
    nack_byte = 0;
    s0 = start_cnt; p0 = stop_cnt;
    @(posedge sys_clk); #1;
    run_xfer(24'h7800B3, 1'b0, lat);
    n_cmp++; if (lat !== FULL_LAT)   begin n_bad++; $display("FAIL single_latency: got %0d want %0d", lat, FULL_LAT); end
    n_cmp++; if (ack_err !== 1'b0)   begin n_bad++; $display("FAIL single_ack_err: got %b want 0", ack_err); end
    n_cmp++; if (busy !== 1'b1)      begin n_bad++; $display("FAIL single_busy_at_done: got %b want 1", busy); end
    n_cmp++; if (cap[0] !== 8'h78)   begin n_bad++; $display("FAIL single_byte0: got %h want 78", cap[0]); end
    n_cmp++; if (cap[1] !== 8'h00)   begin n_bad++; $display("FAIL single_byte1: got %h want 00", cap[1]); end
    n_cmp++; if (cap[2] !== 8'hB3)   begin n_bad++; $display("FAIL single_byte2: got %h want b3", cap[2]); end
    n_cmp++; if (byte_idx !== 3)     begin n_bad++; $display("FAIL single_nbytes: got %0d want 3", byte_idx); end
    n_cmp++; if (start_cnt - s0 !== 1) begin n_bad++; $display("FAIL single_starts: got %0d want 1", start_cnt - s0); end
    n_cmp++; if (stop_cnt - p0 !== 1)  begin n_bad++; $display("FAIL single_stops: got %0d want 1", stop_cnt - p0); end
    @(negedge sys_clk);
    n_cmp++; if (write_done !== 1'b0) begin n_bad++; $display("FAIL single_done_width: got %b want 0", write_done); end
    n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL single_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    int lat1, lat2, s0;
    nack_byte = 0;
    s0 = start_cnt;
    @(posedge sys_clk); #1;
    run_xfer(24'h7840FF, 1'b1, lat1);
    n_cmp++; if (lat1 !== FULL_LAT) begin n_bad++; $display("FAIL b2b_lat1: got %0d want %0d", lat1, FULL_LAT); end
    n_cmp++; if (cap[1] !== 8'h40 || cap[2] !== 8'hFF) begin
      n_bad++; $display("FAIL b2b_word1: got %h%h want 40ff", cap[1], cap[2]); end
    // New word appears the cycle after write_done; that cycle is the accept.
    @(posedge sys_clk); #1;
    run_xfer(24'h784000, 1'b0, lat2);
    n_cmp++; if (lat2 !== FULL_LAT) begin n_bad++; $display("FAIL b2b_lat2: got %0d want %0d", lat2, FULL_LAT); end
    n_cmp++; if (cap[1] !== 8'h40 || cap[2] !== 8'h00) begin
      n_bad++; $display("FAIL b2b_word2: got %h%h want 4000", cap[1], cap[2]); end
    repeat (300) @(negedge sys_clk);
    n_cmp++; if (start_cnt - s0 !== 2) begin n_bad++; $display("FAIL b2b_starts: got %0d want 2", start_cnt - s0); end
    n_cmp++; if (busy !== 1'b0)        begin n_bad++; $display("FAIL b2b_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_nack;
    int lat, p0;
    localparam int NACK2_LAT = 1 + 4 * Q_FAST * 20;   // 2481
    nack_byte = 2;
    p0 = stop_cnt;
    @(posedge sys_clk); #1;
    run_xfer(24'h7800B3, 1'b0, lat);
    n_cmp++; if (lat !== NACK2_LAT) begin n_bad++; $display("FAIL nack_latency: got %0d want %0d", lat, NACK2_LAT); end
    n_cmp++; if (ack_err !== 1'b1)  begin n_bad++; $display("FAIL nack_ack_err: got %b want 1", ack_err); end
    n_cmp++; if (byte_idx !== 2)    begin n_bad++; $display("FAIL nack_nbytes: got %0d want 2", byte_idx); end
    n_cmp++; if (stop_cnt - p0 !== 1) begin n_bad++; $display("FAIL nack_stops: got %0d want 1", stop_cnt - p0); end
    repeat (40) @(negedge sys_clk);
    n_cmp++; if (ack_err !== 1'b1)  begin n_bad++; $display("FAIL nack_hold_idle: got %b want 1", ack_err); end
    nack_byte = 0;
  endtask

  // Starts a transfer, checks ack_err clears on accept, then resets in q0 of
  // bit 5 of byte 2 (slot 14 begins at N+1+14*4*Q = N+1737).
  task automatic test_reset_mid;
    int lat, early_done;
    localparam int HIT = 1737 + 10;
    early_done = 0;
    @(posedge sys_clk); #1;
    write_data = 24'h7800B3;
    write_req  = 1'b1;
    for (int k = 0; k <= HIT; k++) begin
      @(negedge sys_clk);
      if (k == 1) begin
        write_req = 1'b0;
        n_cmp++; if (ack_err !== 1'b0) begin n_bad++; $display("FAIL ack_err_clear_on_accept: got %b want 0", ack_err); end
      end
      if (write_done) early_done++;
    end
    n_cmp++; if (iic_scl !== 1'b0 || iic_sda !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL mid_pre_reset: scl=%b sda=%b busy=%b want 0 0 1", iic_scl, iic_sda, busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (iic_scl !== 1'b1)    begin n_bad++; $display("FAIL mid_reset_scl: got %b want 1", iic_scl); end
    n_cmp++; if (iic_sda !== 1'b1)    begin n_bad++; $display("FAIL mid_reset_sda: got %b want 1 (released)", iic_sda); end
    n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
    for (int k = 0; k < 20; k++) begin
      @(negedge sys_clk);
      if (write_done) early_done++;
    end
    @(posedge sys_clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge sys_clk);
      if (write_done) early_done++;
    end
    n_cmp++; if (early_done !== 0) begin n_bad++; $display("FAIL mid_reset_no_done: got %0d pulses want 0", early_done); end
    @(posedge sys_clk); #1;
    run_xfer(24'h7840A5, 1'b0, lat);
    n_cmp++; if (lat !== FULL_LAT) begin n_bad++; $display("FAIL post_reset_latency: got %0d want %0d", lat, FULL_LAT); end
    n_cmp++; if (cap[0] !== 8'h78 || cap[1] !== 8'h40 || cap[2] !== 8'hA5) begin
      n_bad++; $display("FAIL post_reset_word: got %h%h%h want 7840a5", cap[0], cap[1], cap[2]); end
    n_cmp++; if (ack_err !== 1'b0) begin n_bad++; $display("FAIL post_reset_ack_err: got %b want 0", ack_err); end
  endtask

  // 100 kHz instance: nobody ACKs, so byte 1 is NACKed (11 slots).
  task automatic test_timing;
    int lat, f1, r1, f2, r2, hi_changes, bad_idle;
    logic ps, pd;
    localparam int SLOW_LAT = 1 + 4 * Q_SLOW * 11;    // 5501
    bad_idle = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge sys_clk);
      if (scl_s !== 1'b1 || sda_s !== 1'b1 || busy_s !== 1'b0) bad_idle++;
    end
    n_cmp++; if (bad_idle !== 0) begin n_bad++; $display("FAIL slow_idle: got %0d bad cycles want 0", bad_idle); end
    f1 = -1; r1 = -1; f2 = -1; r2 = -1; hi_changes = 0; lat = -1;
    ps = 1'b1; pd = 1'b1;
    @(posedge sys_clk); #1;
    write_data_s = 24'h7800B3;
    write_req_s  = 1'b1;
    for (int k = 0; k < LIMIT; k++) begin
      @(negedge sys_clk);
      if (k == 1) write_req_s = 1'b0;
      if (ps && scl_s && (sda_s !== pd)) hi_changes++;
      if (ps && !scl_s) begin
        if (f1 < 0) f1 = k;
        else if (r1 >= 0 && f2 < 0) f2 = k;
      end
      if (!ps && scl_s) begin
        if (r1 < 0) r1 = k;
        else if (f2 >= 0 && r2 < 0) r2 = k;
      end
      ps = scl_s;
      pd = sda_s;
      if (write_done_s) begin
        lat = k;
        break;
      end
    end
    n_cmp++; if (lat !== SLOW_LAT)   begin n_bad++; $display("FAIL slow_latency: got %0d want %0d", lat, SLOW_LAT); end
    n_cmp++; if (ack_err_s !== 1'b1) begin n_bad++; $display("FAIL slow_ack_err: got %b want 1", ack_err_s); end
    n_cmp++; if (f2 - r1 !== 2 * Q_SLOW) begin n_bad++; $display("FAIL slow_scl_high: got %0d want %0d", f2 - r1, 2 * Q_SLOW); end
    n_cmp++; if (r2 - f2 !== 2 * Q_SLOW) begin n_bad++; $display("FAIL slow_scl_low: got %0d want %0d", r2 - f2, 2 * Q_SLOW); end
    n_cmp++; if (hi_changes !== 2)   begin n_bad++; $display("FAIL slow_sda_stable: got %0d edges under SCL high want 2", hi_changes); end
    bad_idle = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge sys_clk);
      if (scl_s !== 1'b1 || sda_s !== 1'b1 || busy_s !== 1'b0 || write_done_s !== 1'b0) bad_idle++;
    end
    n_cmp++; if (bad_idle !== 0) begin n_bad++; $display("FAIL slow_idle_after: got %0d bad cycles want 0", bad_idle); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_nack();
    test_reset_mid();
    test_timing();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
